// File: rtl/hex_sr_loader.sv
// Loader/peek controller for an external recirculating shift register.
// Tracks which logical slot sits at sr_q and writes or reads slots as they pass.
module hex_sr_loader #(
  parameter int LENGTH = 66,
  parameter int WIDTH  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             load_abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             peek_req,
  input  logic [6:0]       peek_idx,
  output logic             peek_valid,
  output logic [WIDTH-1:0] peek_data,
  input  logic [WIDTH-1:0] sr_q,
  output logic             sr_recirc,
  output logic [WIDTH-1:0] sr_data,
  output logic [6:0]       rot,
  output logic             frame_sync,
  output logic             busy,
  output logic             load_done
);

  localparam logic [6:0] LAST = 7'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEEK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       rot_q, rot_d;
  logic [6:0]       next_idx_q, next_idx_d;
  logic [6:0]       peek_idx_q, peek_idx_d;
  logic             peek_valid_q, peek_valid_d;
  logic [WIDTH-1:0] peek_data_q, peek_data_d;
  logic             load_done_q, load_done_d;
  logic [6:0]       peek_idx_clamped;

  // The slot counter runs in every state so it always matches the physical rotation.
  assign rot_d            = (rot_q == LAST) ? 7'd0 : rot_q + 7'd1;
  assign peek_idx_clamped = (peek_idx > LAST) ? LAST : peek_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rot_q        <= 7'd0;
      next_idx_q   <= 7'd0;
      peek_idx_q   <= 7'd0;
      peek_valid_q <= 1'b0;
      peek_data_q  <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rot_q        <= rot_d;
      next_idx_q   <= next_idx_d;
      peek_idx_q   <= peek_idx_d;
      peek_valid_q <= peek_valid_d;
      peek_data_q  <= peek_data_d;
      load_done_q  <= load_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_idx_d   = next_idx_q;
    peek_idx_d   = peek_idx_q;
    peek_valid_d = 1'b0;
    peek_data_d  = peek_data_q;
    load_done_d  = 1'b0;
    in_ready     = 1'b0;
    sr_recirc    = 1'b1;
    sr_data      = sr_q;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          next_idx_d = 7'd0;
        end else if (peek_req) begin
          state_d    = PEEK;
          peek_idx_d = peek_idx_clamped;
        end
      end

      LOAD: begin
        in_ready = (rot_q == next_idx_q);
        if (in_valid && in_ready) begin
          sr_recirc  = 1'b0;
          sr_data    = in_data;
          next_idx_d = next_idx_q + 7'd1;
          if (next_idx_q == LAST) begin
            state_d     = IDLE;
            next_idx_d  = 7'd0;
            load_done_d = 1'b1;
          end
        end
        // Abort still lets a concurrent transfer land but never reports completion.
        if (load_abort) begin
          state_d     = IDLE;
          next_idx_d  = 7'd0;
          load_done_d = 1'b0;
        end
      end

      PEEK: begin
        if (rot_q == peek_idx_q) begin
          peek_valid_d = 1'b1;
          peek_data_d  = sr_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rot        = rot_q;
  assign frame_sync = (rot_q == 7'd0);
  assign busy       = (state_q != IDLE);
  assign peek_valid = peek_valid_q;
  assign peek_data  = peek_data_q;
  assign load_done  = load_done_q;

endmodule
